ooo_result_engine: RTL and testbench

Parametrised successor of the single-channel demo DUT that drives vld_i/vld_o/result. It accepts tagged requests into a SLOTS-deep pool, each with its own per-request latency, and returns tagged results. Completion order depends on latency, so results come back out of order unless IN_ORDER mode is selected. It is the DUT for the out-of-order scoreboard environment and also exercises backpressure and in-order mode.

---
 rtl/ooo_result_engine.sv | 131 +++++++++++++
 tb/tb_ooo_result_engine.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ooo_result_engine.sv
// Tagged request pool: each request waits out its own latency, then retires through a
// single output register, either out of order (lowest done slot) or in acceptance order.
module ooo_result_engine #(
    parameter int DATA_W   = 4,
    parameter int ID_W     = 4,
    parameter int LAT_W    = 4,
    parameter int SLOTS    = 4,
    parameter int IN_ORDER = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vld_i,
    output logic                       rdy_o,
    input  logic [ID_W-1:0]            id_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic [LAT_W-1:0]           lat_i,
    output logic                       vld_o,
    input  logic                       rdy_i,
    output logic [ID_W-1:0]            id_o,
    output logic [DATA_W-1:0]          result_o,
    output logic [$clog2(SLOTS):0]     count_o
);

    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int SEQ_W = $clog2(2 * SLOTS);
    localparam int CNT_W = $clog2(SLOTS) + 1;
    localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(2 * SLOTS - 1);

    logic [SLOTS-1:0]  busy;
    logic [ID_W-1:0]   slot_id  [SLOTS];
    logic [DATA_W-1:0] slot_res [SLOTS];
    logic [LAT_W-1:0]  slot_cnt [SLOTS];
    logic [SEQ_W-1:0]  slot_seq [SLOTS];
    logic [SEQ_W-1:0]  alloc_seq;
    logic [SEQ_W-1:0]  retire_seq;

    logic              alloc_found;
    logic [IDX_W-1:0]  alloc_idx;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic              accept;
    logic              out_free;
    logic              xfer;
    logic [CNT_W-1:0]  occupancy;

    // Sequence numbers wrap at 2*SLOTS so in-flight seqs stay unique even when SLOTS isn't a power of two.
    function automatic logic [SEQ_W-1:0] seq_inc(input logic [SEQ_W-1:0] s);
        return (s == SEQ_MAX) ? '0 : s + SEQ_W'(1);
    endfunction

    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
    end

    // In-order mode only admits the slot carrying the next retire sequence number.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (busy[i] && (slot_cnt[i] == '0) &&
                ((IN_ORDER == 0) || (slot_seq[i] == retire_seq))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        occupancy = CNT_W'(vld_o);
        for (int i = 0; i < SLOTS; i++) begin
            occupancy = occupancy + CNT_W'(busy[i]);
        end
    end

    assign rdy_o    = !rst && alloc_found;
    assign accept   = vld_i && rdy_o;
    assign out_free = !vld_o || rdy_i;
    assign xfer     = out_free && sel_found;
    assign count_o  = occupancy;

    // The accept target is always a free slot and the retire source a busy one, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            vld_o      <= 1'b0;
            id_o       <= '0;
            result_o   <= '0;
            alloc_seq  <= '0;
            retire_seq <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_id[i]  <= '0;
                slot_res[i] <= '0;
                slot_cnt[i] <= '0;
                slot_seq[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (busy[i] && (slot_cnt[i] != '0)) begin
                    slot_cnt[i] <= slot_cnt[i] - LAT_W'(1);
                end
            end

            if (xfer) begin
                busy[sel_idx] <= 1'b0;
                id_o          <= slot_id[sel_idx];
                result_o      <= slot_res[sel_idx];
                vld_o         <= 1'b1;
                retire_seq    <= seq_inc(retire_seq);
            end else if (out_free) begin
                vld_o <= 1'b0;
            end

            if (accept) begin
                busy[alloc_idx]     <= 1'b1;
                slot_id[alloc_idx]  <= id_i;
                slot_res[alloc_idx] <= data_i + DATA_W'(1);
                slot_cnt[alloc_idx] <= lat_i;
                slot_seq[alloc_idx] <= alloc_seq;
                alloc_seq           <= seq_inc(alloc_seq);
            end
        end
    end

endmodule

// File: tb/tb_ooo_result_engine.sv
// Directed bench: one out-of-order and one in-order instance share the same stimulus
// and are checked cycle by cycle against hand-derived expectations.
module tb_ooo_result_engine;

    localparam int DATA_W = 4;
    localparam int ID_W   = 4;
    localparam int LAT_W  = 4;
    localparam int SLOTS  = 4;
    localparam int CNT_W  = $clog2(SLOTS) + 1;

    logic              clk;
    logic              rst;
    logic              vld_i;
    logic [ID_W-1:0]   id_i;
    logic [DATA_W-1:0] data_i;
    logic [LAT_W-1:0]  lat_i;
    logic              rdy_i;

    logic              rdy_a, vld_a, rdy_b, vld_b;
    logic [ID_W-1:0]   id_a, id_b;
    logic [DATA_W-1:0] res_a, res_b;
    logic [CNT_W-1:0]  cnt_a, cnt_b;

    int tests_run = 0;
    int tests_failed = 0;

    ooo_result_engine #(.DATA_W(DATA_W), .ID_W(ID_W), .LAT_W(LAT_W), .SLOTS(SLOTS), .IN_ORDER(0)) dut_ooo (
        .clk(clk), .rst(rst), .vld_i(vld_i), .rdy_o(rdy_a), .id_i(id_i), .data_i(data_i),
        .lat_i(lat_i), .vld_o(vld_a), .rdy_i(rdy_i), .id_o(id_a), .result_o(res_a), .count_o(cnt_a)
    );

    ooo_result_engine #(.DATA_W(DATA_W), .ID_W(ID_W), .LAT_W(LAT_W), .SLOTS(SLOTS), .IN_ORDER(1)) dut_ino (
        .clk(clk), .rst(rst), .vld_i(vld_i), .rdy_o(rdy_b), .id_i(id_i), .data_i(data_i),
        .lat_i(lat_i), .vld_o(vld_b), .rdy_i(rdy_i), .id_o(id_b), .result_o(res_b), .count_o(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic v, input int id, input int data, input int lat, input logic r);
        vld_i  = v;
        id_i   = ID_W'(id);
        data_i = DATA_W'(data);
        lat_i  = LAT_W'(lat);
        rdy_i  = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected retire streams for the backpressure release, edges E6..E10.
    int bp_id_a  [5] = '{6, 5, 9, 7, 8};
    int bp_res_a [5] = '{3, 2, 6, 4, 5};
    int bp_id_b  [5] = '{5, 6, 7, 8, 9};
    int bp_res_b [5] = '{2, 3, 4, 5, 6};
    int bp_cnt   [5] = '{4, 4, 3, 2, 1};

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 1);
        #1;
        checkOutput("rdy_in_reset_t0", rdy_a, 0);
        tick();
        tick();
        checkOutput("reset_vld", vld_a, 0);
        checkOutput("reset_id", id_a, 0);
        checkOutput("reset_res", res_a, 0);
        checkOutput("reset_cnt", cnt_a, 0);
        checkOutput("reset_rdy_held", rdy_a, 0);
        checkOutput("reset_cnt_ino", cnt_b, 0);
        rst = 1'b0;
        #1;
        checkOutput("rdy_after_release", rdy_a, 1);
        checkOutput("rdy_after_release_ino", rdy_b, 1);

        // Single request, zero latency
        applyStimulus(1, 3, 5, 0, 1);
        tick();
        checkOutput("single_accept_cnt", cnt_a, 1);
        checkOutput("single_accept_vld", vld_a, 0);
        applyStimulus(0, 0, 0, 0, 1);
        tick();
        checkOutput("single_vld", vld_a, 1);
        checkOutput("single_id", id_a, 3);
        checkOutput("single_res", res_a, 6);
        checkOutput("single_cnt_out", cnt_a, 1);
        checkOutput("single_id_ino", id_b, 3);
        tick();
        checkOutput("single_done_vld", vld_a, 0);
        checkOutput("single_done_cnt", cnt_a, 0);

        // Out-of-order vs in-order: (id1,lat6) then (id2,lat1)
        applyStimulus(1, 1, 10, 6, 1);
        tick();
        applyStimulus(1, 2, 7, 1, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 1);
        tick();
        checkOutput("ooo_e2_vld", vld_a, 0);
        tick();
        checkOutput("ooo_e3_vld", vld_a, 1);
        checkOutput("ooo_e3_id", id_a, 2);
        checkOutput("ooo_e3_res", res_a, 8);
        checkOutput("ino_e3_vld", vld_b, 0);
        tick();
        checkOutput("ooo_e4_vld", vld_a, 0);
        tick();
        tick();
        checkOutput("ooo_e6_vld", vld_a, 0);
        checkOutput("ino_e6_vld", vld_b, 0);
        tick();
        checkOutput("ooo_e7_vld", vld_a, 1);
        checkOutput("ooo_e7_id", id_a, 1);
        checkOutput("ooo_e7_res", res_a, 11);
        checkOutput("ooo_e7_cnt", cnt_a, 1);
        checkOutput("ino_e7_vld", vld_b, 1);
        checkOutput("ino_e7_id", id_b, 1);
        checkOutput("ino_e7_cnt", cnt_b, 2);
        tick();
        checkOutput("ooo_e8_vld", vld_a, 0);
        checkOutput("ooo_e8_cnt", cnt_a, 0);
        checkOutput("ino_e8_vld", vld_b, 1);
        checkOutput("ino_e8_id", id_b, 2);
        checkOutput("ino_e8_res", res_b, 8);
        tick();
        checkOutput("ino_e9_vld", vld_b, 0);
        checkOutput("ino_e9_cnt", cnt_b, 0);

        // Full pool under backpressure: output register plus four slots absorb five requests
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 4 + k, k, 0, 0);
            tick();
        end
        checkOutput("full_cnt", cnt_a, 5);
        checkOutput("full_rdy", rdy_a, 0);
        checkOutput("full_cnt_ino", cnt_b, 5);
        applyStimulus(1, 9, 5, 0, 0);
        tick();
        checkOutput("bp_hold_vld", vld_a, 1);
        checkOutput("bp_hold_id", id_a, 4);
        checkOutput("bp_hold_res", res_a, 1);
        checkOutput("bp_hold_cnt", cnt_a, 5);
        checkOutput("bp_hold_rdy", rdy_a, 0);
        checkOutput("bp_hold_id_ino", id_b, 4);
        for (int j = 0; j < 5; j++) begin
            applyStimulus((j <= 1), 9, 5, 0, 1);
            tick();
            checkOutput($sformatf("bp_rel%0d_vld", j), vld_a, 1);
            checkOutput($sformatf("bp_rel%0d_id", j), id_a, 32'(bp_id_a[j]));
            checkOutput($sformatf("bp_rel%0d_res", j), res_a, 32'(bp_res_a[j]));
            checkOutput($sformatf("bp_rel%0d_cnt", j), cnt_a, 32'(bp_cnt[j]));
            checkOutput($sformatf("bp_rel%0d_id_ino", j), id_b, 32'(bp_id_b[j]));
            checkOutput($sformatf("bp_rel%0d_res_ino", j), res_b, 32'(bp_res_b[j]));
            checkOutput($sformatf("bp_rel%0d_cnt_ino", j), cnt_b, 32'(bp_cnt[j]));
        end
        checkOutput("bp_rel0_rdy_after", rdy_a, 1);
        tick();
        checkOutput("bp_drain_vld", vld_a, 0);
        checkOutput("bp_drain_cnt", cnt_a, 0);
        checkOutput("bp_drain_cnt_ino", cnt_b, 0);

        // Nine streamed requests: data wrap (15 -> 0) and sequence-number wrap in order mode
        applyStimulus(1, 0, 15, 0, 1);
        tick();
        for (int k = 1; k <= 9; k++) begin
            applyStimulus((k < 9), k, k - 1, 0, 1);
            tick();
            checkOutput($sformatf("wrap%0d_vld", k - 1), vld_a, 1);
            checkOutput($sformatf("wrap%0d_id", k - 1), id_a, 32'(k - 1));
            checkOutput($sformatf("wrap%0d_res", k - 1), res_a, 32'(k - 1));
            checkOutput($sformatf("wrap%0d_id_ino", k - 1), id_b, 32'(k - 1));
            checkOutput($sformatf("wrap%0d_vld_ino", k - 1), vld_b, 1);
        end
        applyStimulus(0, 0, 0, 0, 1);
        tick();
        checkOutput("wrap_drain_vld_ino", vld_b, 0);
        checkOutput("wrap_drain_cnt_ino", cnt_b, 0);

        // Reset with three requests in flight discards them
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1, k, k, 5, 1);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("pre_rst_cnt", cnt_a, 3);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_cnt", cnt_a, 0);
        checkOutput("mid_rst_vld", vld_a, 0);
        checkOutput("mid_rst_rdy", rdy_a, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_rdy", rdy_a, 1);
        checkOutput("post_rst_rdy_ino", rdy_b, 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput($sformatf("post_rst%0d_vld", k), vld_a, 0);
            checkOutput($sformatf("post_rst%0d_vld_ino", k), vld_b, 0);
            checkOutput($sformatf("post_rst%0d_cnt", k), cnt_a, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
